// File: rtl/operand_scale_extractor.sv
// Operand scale extractor: splits aligned sign-magnitude blocks into
// per-lane micro-scales plus right-shifted magnitudes, so that shifting
// each magnitude back left by its lane scale restores the input.
// Lanes are processed LANES_PER_CYCLE at a time over a fixed number of
// SCAN cycles, which gives a latency that does not depend on the data.

// One lane: looks at the four elements of its 1:4 group, picks its own
// pair (hi selects the upper pair), and derives scale and shifted pair.
module operand_scale_lane #(
    parameter int ELEM_W  = 8,
    parameter int SCALE_W = 8
) (
    input  logic [4*ELEM_W-1:0] quad,
    input  logic                hi,
    input  logic                mode,
    output logic [SCALE_W-1:0]  scale,
    output logic [2*ELEM_W-1:0] elems
);
    localparam int MAG_W = ELEM_W - 1;
    localparam int TZ_W  = $clog2(MAG_W + 1);

    // Trailing-zero count; a zero magnitude returns MAG_W so it never wins the min.
    function automatic logic [TZ_W-1:0] tz_of(input logic [MAG_W-1:0] m);
        tz_of = TZ_W'(MAG_W);
        for (int i = MAG_W - 1; i >= 0; i--)
            if (m[i]) tz_of = TZ_W'(i);
    endfunction

    logic [TZ_W-1:0]   s_min;
    logic [TZ_W-1:0]   s;
    logic [ELEM_W-1:0] e;

    // Minimum trailing zeros over the elements sharing this scale, then shift the own pair.
    always_comb begin
        s_min = TZ_W'(MAG_W);
        for (int k = 0; k < 4; k++)
            if ((mode || ((k >= 2) == hi)) && (tz_of(quad[k*ELEM_W +: MAG_W]) < s_min))
                s_min = tz_of(quad[k*ELEM_W +: MAG_W]);
        // All-zero group keeps scale 0
        s = (s_min == TZ_W'(MAG_W)) ? '0 : s_min;
        scale = SCALE_W'(s);
        elems = '0;
        for (int p = 0; p < 2; p++) begin
            e = quad[((hi ? 2 : 0) + p)*ELEM_W +: ELEM_W];
            elems[p*ELEM_W +: ELEM_W] = {e[ELEM_W-1], MAG_W'(e[MAG_W-1:0] >> s)};
        end
    end
endmodule

module operand_scale_extractor #(
    parameter int NUM_ELEM        = 32,
    parameter int NUM_LANES       = 16,
    parameter int ELEM_W          = 8,
    parameter int SCALE_W         = 8,
    parameter int LANES_PER_CYCLE = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_in,
    output logic                          ready_in,
    input  logic [NUM_ELEM*ELEM_W-1:0]    in_elements,
    input  logic                          in_sharing_mode,
    output logic                          valid_out,
    input  logic                          ready_out,
    output logic [NUM_ELEM*ELEM_W-1:0]    out_elements,
    output logic [NUM_LANES*SCALE_W-1:0]  out_micro_scales,
    output logic                          out_sharing_mode
);
    localparam int NUM_STEPS = NUM_LANES / LANES_PER_CYCLE;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int WIN_EW    = LANES_PER_CYCLE * 2 * ELEM_W;
    localparam int WIN_SW    = LANES_PER_CYCLE * SCALE_W;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [NUM_ELEM*ELEM_W-1:0]     in_elem_q, in_elem_d;
    logic                           mode_q, mode_d;
    logic [NUM_ELEM*ELEM_W-1:0]     out_elem_q, out_elem_d;
    logic [NUM_LANES*SCALE_W-1:0]   out_scale_q, out_scale_d;

    logic [WIN_EW-1:0]                             win_in;
    logic [LANES_PER_CYCLE-1:0][2*ELEM_W-1:0]      win_out;
    logic [LANES_PER_CYCLE-1:0][SCALE_W-1:0]       win_scale;

    // Elements of the lanes handled in the current SCAN step
    assign win_in = in_elem_q[cnt_q*WIN_EW +: WIN_EW];

    // Lane pairs 2g/2g+1 share one quad so 1:4 mode sees its whole group
    for (genvar j = 0; j < LANES_PER_CYCLE; j++) begin : g_lane
        operand_scale_lane #(.ELEM_W(ELEM_W), .SCALE_W(SCALE_W)) u_lane (
            .quad  (win_in[(j/2)*4*ELEM_W +: 4*ELEM_W]),
            .hi    (j % 2 == 1),
            .mode  (mode_q),
            .scale (win_scale[j]),
            .elems (win_out[j])
        );
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: fixed NUM_STEPS scan cycles, then hold until drained
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_in) state_d = SCAN;
            SCAN:    if (cnt_q == CNT_W'(NUM_STEPS - 1)) state_d = DONE;
            DONE:    if (ready_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs depend only on state
    always_comb begin
        ready_in  = (state_q == IDLE);
        valid_out = (state_q == DONE);
    end

    // Datapath next values: capture on accept, fill one window per SCAN step
    always_comb begin
        cnt_d       = cnt_q;
        in_elem_d   = in_elem_q;
        mode_d      = mode_q;
        out_elem_d  = out_elem_q;
        out_scale_d = out_scale_q;
        if (state_q == IDLE && valid_in) begin
            in_elem_d = in_elements;
            mode_d    = in_sharing_mode;
            cnt_d     = '0;
        end else if (state_q == SCAN) begin
            out_elem_d[cnt_q*WIN_EW +: WIN_EW]  = win_out;
            out_scale_d[cnt_q*WIN_SW +: WIN_SW] = win_scale;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            in_elem_q   <= '0;
            mode_q      <= 1'b0;
            out_elem_q  <= '0;
            out_scale_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            in_elem_q   <= in_elem_d;
            mode_q      <= mode_d;
            out_elem_q  <= out_elem_d;
            out_scale_q <= out_scale_d;
        end
    end

    assign out_elements     = out_elem_q;
    assign out_micro_scales = out_scale_q;
    assign out_sharing_mode = mode_q;
endmodule

// File: tb/tb_operand_scale_extractor.sv
// Directed bench for operand_scale_extractor plus a random round-trip
// section that rebuilds inputs from outputs and checks scale minimality.
module tb_operand_scale_extractor;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_in = 1'b0;
    logic         ready_in;
    logic [255:0] in_elements = '0;
    logic         in_sharing_mode = 1'b0;
    logic         valid_out;
    logic         ready_out = 1'b0;
    logic [255:0] out_elements;
    logic [127:0] out_micro_scales;
    logic         out_sharing_mode;

    int n_cmp = 0;
    int n_err = 0;

    operand_scale_extractor dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
        .in_elements(in_elements), .in_sharing_mode(in_sharing_mode),
        .valid_out(valid_out), .ready_out(ready_out), .out_elements(out_elements),
        .out_micro_scales(out_micro_scales), .out_sharing_mode(out_sharing_mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] put(input logic [255:0] v, input int idx, input logic [7:0] b);
        v[idx*8 +: 8] = b;
        return v;
    endfunction

    // Present a block and wait for the accept edge; scramble inputs afterwards.
    task automatic do_accept(input logic [255:0] el, input logic md);
        int t = 0;
        in_elements = el; in_sharing_mode = md; valid_in = 1'b1;
        while (!ready_in && t < 20) begin @(posedge clk); #1; t++; end
        chk("accept_ready", ready_in, 1);
        @(posedge clk); #1;
        valid_in = 1'b0; in_elements = '1; in_sharing_mode = ~md;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!valid_out && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic check_block(input string tag, input logic [255:0] el, input logic [255:0] sc, input logic md);
        int lat;
        wait_done(lat);
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_el"}, out_elements, el);
        chk({tag, "_sc"}, out_micro_scales, sc);
        chk({tag, "_md"}, out_sharing_mode, md);
    endtask

    task automatic handshake(input string tag);
        ready_out = 1'b1;
        @(posedge clk); #1;
        ready_out = 1'b0;
        chk({tag, "_vo_drop"}, valid_out, 0);
        chk({tag, "_idle"}, ready_in, 1);
    endtask

    // Random block, then rebuild it from the outputs and check minimal scales.
    task automatic rt_block(input int b);
        logic [255:0] el = '0;
        logic         md = b[0];
        int           errs = 0;
        int           lat, s, om, lo, hi_i;
        bit           odd;
        for (int i = 0; i < 32; i++) begin
            int sh = $urandom_range(0, 6);
            logic [6:0] m = 7'($urandom_range(0, 127) << sh);
            if ($urandom_range(0, 4) == 0) m = '0;
            el[i*8 +: 8] = {1'($urandom_range(0, 1)), m};
        end
        do_accept(el, md);
        wait_done(lat);
        chk("rt_lat", lat, 4);
        for (int i = 0; i < 32; i++) begin
            s  = int'(out_micro_scales[(i/2)*8 +: 8]);
            om = int'(out_elements[i*8 +: 7]);
            if (s > 6) errs++;
            if ((om << s) != int'(el[i*8 +: 7])) errs++;
            if (out_elements[i*8+7] !== el[i*8+7]) errs++;
        end
        for (int k = 0; k < 16; k++) begin
            s    = int'(out_micro_scales[k*8 +: 8]);
            lo   = md ? (k/2)*4 : k*2;
            hi_i = md ? lo + 3 : lo + 1;
            odd  = 1'b0;
            for (int i = lo; i <= hi_i; i++) if (out_elements[i*8]) odd = 1'b1;
            if (s > 0 && !odd) errs++;
            if (md && k[0] && out_micro_scales[k*8 +: 8] !== out_micro_scales[(k-1)*8 +: 8]) errs++;
        end
        chk("rt_block", errs, 0);
        handshake("rt");
    endtask

    logic [255:0] a_in, a_el, a_sc, b_in, b_el, b_sc, c_in, c_el, c_sc;
    int seen;

    initial begin
        // Vector A: mode 0, lane 0 = 04,0C
        a_in = put(put('0, 0, 8'h04), 1, 8'h0C);
        a_el = put(put('0, 0, 8'h01), 1, 8'h03);
        a_sc = put('0, 0, 8'h02);
        // Vector B: mode 0 mixed sign/zero, plus lanes 9 and 15
        b_in = '0; b_el = '0; b_sc = '0;
        b_in = put(b_in, 0, 8'h88); b_in = put(b_in, 1, 8'h10);
        b_in = put(b_in, 2, 8'h80); b_in = put(b_in, 4, 8'h40);
        b_in = put(b_in, 18, 8'h7F); b_in = put(b_in, 19, 8'h02);
        b_in = put(b_in, 30, 8'h60); b_in = put(b_in, 31, 8'hA0);
        b_el = put(b_el, 0, 8'h81); b_el = put(b_el, 1, 8'h02);
        b_el = put(b_el, 2, 8'h80); b_el = put(b_el, 4, 8'h01);
        b_el = put(b_el, 18, 8'h7F); b_el = put(b_el, 19, 8'h02);
        b_el = put(b_el, 30, 8'h03); b_el = put(b_el, 31, 8'h81);
        b_sc = put(b_sc, 0, 8'h03); b_sc = put(b_sc, 2, 8'h06); b_sc = put(b_sc, 15, 8'h05);
        // Vector C: mode 1, groups 0, 3, 7
        c_in = '0; c_el = '0; c_sc = '0;
        c_in = put(c_in, 0, 8'h02); c_in = put(c_in, 1, 8'h04); c_in = put(c_in, 2, 8'h08);
        c_in = put(c_in, 12, 8'h80); c_in = put(c_in, 29, 8'h90); c_in = put(c_in, 31, 8'hC0);
        c_el = put(c_el, 0, 8'h01); c_el = put(c_el, 1, 8'h02); c_el = put(c_el, 2, 8'h04);
        c_el = put(c_el, 12, 8'h80); c_el = put(c_el, 29, 8'h81); c_el = put(c_el, 31, 8'h84);
        c_sc = put(c_sc, 0, 8'h01); c_sc = put(c_sc, 1, 8'h01);
        c_sc = put(c_sc, 14, 8'h04); c_sc = put(c_sc, 15, 8'h04);

        // Reset state
        #12;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_ready_in", ready_in, 1);
        chk("rst_el", out_elements, '0);
        chk("rst_sc", out_micro_scales, '0);
        chk("rst_md", out_sharing_mode, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_accept(a_in, 1'b0);
        check_block("a", a_el, a_sc, 1'b0);
        handshake("a");

        do_accept(b_in, 1'b0);
        check_block("b", b_el, b_sc, 1'b0);
        handshake("b");

        do_accept(c_in, 1'b1);
        check_block("c", c_el, c_sc, 1'b1);
        handshake("c");

        // Backpressure: hold DONE 10 cycles, stray valid_in pulse ignored
        do_accept(b_in, 1'b0);
        check_block("bp", b_el, b_sc, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin valid_in = 1'b1; in_elements = a_in; end
            if (i == 4) valid_in = 1'b0;
            @(posedge clk); #1;
            chk("bp_vo", valid_out, 1);
            chk("bp_ri", ready_in, 0);
            chk("bp_el", out_elements, b_el);
            chk("bp_sc", out_micro_scales, b_sc);
        end
        // Drain with valid_in already high: no accept on the drain edge
        valid_in = 1'b1; in_elements = a_in; in_sharing_mode = 1'b0;
        handshake("bp");
        do_accept(a_in, 1'b0);
        check_block("bp_next", a_el, a_sc, 1'b0);
        handshake("bp_next");

        // Reset while counter is 2
        do_accept(c_in, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("mid_rst_vo", valid_out, 0);
        chk("mid_rst_ri", ready_in, 1);
        chk("mid_rst_el", out_elements, '0);
        chk("mid_rst_sc", out_micro_scales, '0);
        chk("mid_rst_md", out_sharing_mode, 0);
        #3 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (valid_out) seen++;
        end
        chk("mid_rst_no_vo", seen, 0);
        // Accept on the first edge after release
        rst_n = 1'b0;
        in_elements = a_in; in_sharing_mode = 1'b0; valid_in = 1'b1;
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0; in_elements = '1;
        chk("rel_accept", ready_in, 0);
        check_block("rel", a_el, a_sc, 1'b0);
        handshake("rel");

        for (int b = 0; b < 20; b++) rt_block(b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
